input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles needed to accept a new level (10 ms at 50 MHz); legal range 2 to 2^20.
REQ-002 MAX10_CLK1_50  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 SW  input  10  raw slide switches, asynchronous to clock.
REQ-005 KEY  input  2  raw pushbuttons, active-low (0 = pressed), asynchronous to clock.
REQ-006 sw_clean  output  10  debounced switch levels.
REQ-007 key_down  output  2  debounced key state, active-high (1 = held).
REQ-008 key_press  output  2  one-cycle pulse on each debounced press.
REQ-009 key_release  output  2  one-cycle pulse on each debounced release.
REQ-010 mode  output  2  equals sw_clean[9:8]; selects the downstream design (00, 01, 1x).
REQ-011 mode_change  output  1  one-cycle pulse whenever mode changes value.

Function
REQ-012 Each of the 12 raw inputs SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each synchronized bit SHALL have its own stable register q and its own counter cnt of width clog2(DEBOUNCE_CYCLES).
REQ-014 While the synchronized bit equals q, cnt SHALL be held at 0.
REQ-015 While the synchronized bit differs from q, cnt SHALL increment each cycle; when cnt = DEBOUNCE_CYCLES-1 and the bit still differs, q SHALL take the new level and cnt SHALL return to 0 in the same edge.
REQ-016 Any single cycle of agreement during counting SHALL clear cnt to 0; glitches shorter than DEBOUNCE_CYCLES SHALL never reach q.
REQ-017 Latency: a clean raw step SHALL appear on sw_clean/key_down exactly DEBOUNCE_CYCLES+2 clock edges after the first edge that samples it.
REQ-018 key_down[i] SHALL equal the inverse of the debounced KEY[i].
REQ-019 key_press[i] SHALL be 1 for exactly the first cycle in which key_down[i] is 1; key_release[i] SHALL be 1 for exactly the first cycle in which key_down[i] is 0 after being 1.
REQ-020 mode_change SHALL be 1 for exactly the first cycle in which mode differs from its previous-cycle value.
REQ-021 Simultaneous events on independent inputs SHALL each be reported in the same cycle; one input's activity SHALL never affect another input's counter.
REQ-022 The counter SHALL never wrap; it saturates at DEBOUNCE_CYCLES-1 by construction of REQ-015.
REQ-023 All outputs SHALL be registered; no combinational path from SW/KEY to any output.

Reset
REQ-024 While rst_n = 0: KEY synchronizer flops and key q SHALL be 1 (released); SW synchronizer flops and SW q SHALL be 0; all cnt SHALL be 0.
REQ-025 Reset values: sw_clean = 0, key_down = 0, key_press = 0, key_release = 0, mode = 0, mode_change = 0.
REQ-026 Reset asserted mid-count SHALL discard the count; after release the input SHALL need a full DEBOUNCE_CYCLES of stability again.
REQ-027 No key_press, key_release or mode_change pulse SHALL be generated by reset deassertion alone, regardless of raw input levels, until debouncing completes.

Structure
REQ-028 Shared package lab1_pkg SHALL hold DEBOUNCE_CYCLES default and mode encodings MODE_D1 = 2'b00, MODE_D2 = 2'b01, MODE_D3 = 2'b1x.
REQ-029 One sub-module debounce_bit (synchronizer + counter + q, parameterized reset level and DEBOUNCE_CYCLES) SHALL be instantiated 12 times; edge/pulse logic SHALL live in input_conditioner.

Verification (DEBOUNCE_CYCLES = 4)
REQ-030 Reset with KEY = 2'b11, SW = 0 -> all outputs 0; no pulses for 20 cycles after rst_n rises.
REQ-031 SW[3] 0->1 held -> sw_clean[3] = 1 exactly 6 edges later; no other bit changes.
REQ-032 KEY[0] toggles 1,0,1,0 every 2 cycles then holds 0 -> no key_press during bouncing; single key_press[0] pulse 6 edges after the final fall; key_release[0] once after release settles.
REQ-033 KEY[0] and KEY[1] pressed on the same edge -> key_press = 2'b11 for one cycle.
REQ-034 SW[9:8] 00->01 -> mode = 01 and mode_change = 1 for one cycle; 01->11 -> second single pulse.
REQ-035 rst_n pulsed low when cnt = 2 during SW[0] rise -> after reset release sw_clean[0] rises only after a full 6 edges.

Source files
------------

// File: rtl/lab1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lab1_pkg
//  Description : Shared constants for the lab-1 board front end: default
//                debounce interval and downstream-design mode encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package lab1_pkg;

  // 10 ms of stability at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // Mode encodings carried on SW[9:8]; bit 0 is a don't-care for MODE_D3 (2'b1x)
  localparam logic [1:0] MODE_D1      = 2'b00;
  localparam logic [1:0] MODE_D2      = 2'b01;
  localparam logic [1:0] MODE_D3      = 2'b10;
  localparam logic [1:0] MODE_D3_MASK = 2'b10;

  typedef enum logic [1:0] {
    DESIGN_D1 = 2'd0,
    DESIGN_D2 = 2'd1,
    DESIGN_D3 = 2'd2
  } design_e;

  // Map a raw mode value onto the downstream design it selects
  function automatic design_e decode_mode(input logic [1:0] mode);
    if ((mode & MODE_D3_MASK) == MODE_D3) begin
      return DESIGN_D3;
    end else if (mode == MODE_D2) begin
      return DESIGN_D2;
    end else begin
      return DESIGN_D1;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/input_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : input_conditioner_if
//  Description : Raw board inputs and conditioned outputs of the input
//                conditioner. master = board/stimulus side, slave = conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
interface input_conditioner_if;

  logic [9:0] SW;
  logic [1:0] KEY;
  logic [9:0] sw_clean;
  logic [1:0] key_down;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic [1:0] mode;
  logic       mode_change;

  modport master (
    output SW, KEY,
    input  sw_clean, key_down, key_press, key_release, mode, mode_change
  );

  modport slave (
    input  SW, KEY,
    output sw_clean, key_down, key_press, key_release, mode, mode_change
  );

endinterface
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bit
//  Description : One raw input bit: 2-flop synchronizer, stability counter and
//                accepted level q. o_flip is high in the cycle whose clock edge
//                moves q to the new level.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit
  import lab1_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_raw,
  output logic      o_q,
  output logic      o_flip
);

  localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_q;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_differs;

  assign w_differs = (r_sync2 != r_q);

  // Synchronize, then count consecutive disagreeing cycles; accept on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
      r_q     <= RESET_LEVEL;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        r_q   <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  assign o_q    = r_q;
  assign o_flip = w_differs && (r_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : input_conditioner
//  Description : Debounces 10 slide switches and 2 active-low pushbuttons,
//                derives key press/release pulses, the mode field SW[9:8] and
//                a mode-change pulse. All outputs come straight from flops.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner
  import lab1_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input wire logic     MAX10_CLK1_50,
  input wire logic     rst_n,
  input_conditioner_if.slave bus
);

  logic [9:0] w_sw_q;
  logic [9:0] w_sw_flip;
  logic [1:0] w_key_q;
  logic [1:0] w_key_flip;
  logic [1:0] r_key_press;
  logic [1:0] r_key_release;
  logic       r_mode_change;

  for (genvar i = 0; i < 10; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (1'b0)
    ) u_db (
      .clk    (MAX10_CLK1_50),
      .rst_n  (rst_n),
      .i_raw  (bus.SW[i]),
      .o_q    (w_sw_q[i]),
      .o_flip (w_sw_flip[i])
    );
  end

  // Keys idle high (released), so their synchronizers and q reset to 1
  for (genvar i = 0; i < 2; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (1'b1)
    ) u_db (
      .clk    (MAX10_CLK1_50),
      .rst_n  (rst_n),
      .i_raw  (bus.KEY[i]),
      .o_q    (w_key_q[i]),
      .o_flip (w_key_flip[i])
    );
  end

  // Pulses are registered on the same edge that moves q, so they line up with the level change
  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_key_press   <= '0;
      r_key_release <= '0;
      r_mode_change <= 1'b0;
    end else begin
      r_key_press   <= w_key_flip & w_key_q;
      r_key_release <= w_key_flip & ~w_key_q;
      r_mode_change <= |w_sw_flip[9:8];
    end
  end

  assign bus.sw_clean    = w_sw_q;
  assign bus.key_down    = ~w_key_q;
  assign bus.key_press   = r_key_press;
  assign bus.key_release = r_key_release;
  assign bus.mode        = w_sw_q[9:8];
  assign bus.mode_change = r_mode_change;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_conditioner
//  Description : Self-checking bench for input_conditioner with a short
//                debounce interval. A window-based reference model pushes the
//                expected outputs for every clock edge onto a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;
  import lab1_pkg::*;

  localparam int D  = 4;
  localparam int HL = D + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  input_conditioner_if bus ();

  input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .MAX10_CLK1_50 (clk),
    .rst_n         (rst_n),
    .bus           (bus)
  );

  typedef struct packed {
    logic [9:0] sw_clean;
    logic [1:0] key_down;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [1:0] mode;
    logic       mode_change;
  } out_t;

  typedef struct {
    logic       rst_n;
    logic [9:0] sw;
    logic [1:0] key;
    int         hold;
    logic [9:0] exp_sw;
    logic [1:0] exp_kd;
  } vec_t;

  out_t sb[$];
  int   n_vec    = 0;
  int   n_fail   = 0;
  int   n_press0 = 0;
  int   n_rel0   = 0;

  // Reference model: a bit's accepted level flips on edge k when the raw samples
  // taken on edges k-2 .. k-D-1 all disagree with the current accepted level.
  logic [11:0] m_hist [0:HL-1];
  logic [11:0] m_q;
  logic [11:0] m_prev;
  logic [11:0] m_flip;
  logic        m_all;
  out_t        m_exp;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      for (int j = 0; j < HL; j++) m_hist[j] = 12'hC00;
      m_q   = 12'hC00;
      m_exp = '0;
    end else begin
      for (int j = HL - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = {bus.KEY, bus.SW};
      m_prev = m_q;
      m_flip = '0;
      for (int b = 0; b < 12; b++) begin
        m_all = 1'b1;
        for (int j = 2; j < HL; j++) if (m_hist[j][b] == m_q[b]) m_all = 1'b0;
        if (m_all) begin
          m_q[b]    = ~m_q[b];
          m_flip[b] = 1'b1;
        end
      end
      m_exp.sw_clean    = m_q[9:0];
      m_exp.key_down    = ~m_q[11:10];
      m_exp.key_press   = m_flip[11:10] & ~m_q[11:10];
      m_exp.key_release = m_flip[11:10] & m_q[11:10];
      m_exp.mode        = m_q[9:8];
      m_exp.mode_change = (m_q[9:8] != m_prev[9:8]);
    end
    sb.push_back(m_exp);
  end

  // Advance to the next falling edge and compare DUT outputs against the scoreboard
  task automatic tick();
    out_t a;
    out_t e;
    @(negedge clk);
    a = {bus.sw_clean, bus.key_down, bus.key_press, bus.key_release, bus.mode, bus.mode_change};
    if (bus.key_press[0])   n_press0++;
    if (bus.key_release[0]) n_rel0++;
    n_vec++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: got outputs %h, no expected record queued", a);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t: got sw=%h kd=%b kp=%b kr=%b mode=%b mc=%b, want sw=%h kd=%b kp=%b kr=%b mode=%b mc=%b",
                 $time, a.sw_clean, a.key_down, a.key_press, a.key_release, a.mode, a.mode_change,
                 e.sw_clean, e.key_down, e.key_press, e.key_release, e.mode, e.mode_change);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // One tick, then change inputs just after the falling edge
  task automatic set_in(input logic r, input logic [9:0] sw, input logic [1:0] key);
    tick();
    #1;
    rst_n  = r;
    bus.SW = sw;
    bus.KEY = key;
  endtask

  vec_t vecs [6];

  initial begin
    bus.SW  = '0;
    bus.KEY = 2'b11;

    vecs[0] = '{1'b0, 10'h000, 2'b11,  3, 10'h000, 2'b00};
    vecs[1] = '{1'b1, 10'h000, 2'b11, 20, 10'h000, 2'b00};
    vecs[2] = '{1'b1, 10'h3FF, 2'b11,  8, 10'h3FF, 2'b00};
    vecs[3] = '{1'b1, 10'h155, 2'b10,  8, 10'h155, 2'b01};
    vecs[4] = '{1'b1, 10'h2AA, 2'b01,  8, 10'h2AA, 2'b10};
    vecs[5] = '{1'b1, 10'h000, 2'b11,  8, 10'h000, 2'b00};

    for (int i = 0; i < 6; i++) begin
      set_in(vecs[i].rst_n, vecs[i].sw, vecs[i].key);
      repeat (vecs[i].hold) tick();
      chk("tbl_sw_clean", 32'(bus.sw_clean), 32'(vecs[i].exp_sw));
      chk("tbl_key_down", 32'(bus.key_down), 32'(vecs[i].exp_kd));
    end

    // Single switch step: visible exactly D+2 edges after the first sampling edge
    set_in(1'b1, 10'h008, 2'b11);
    repeat (5) tick();
    chk("sw3_edge5", 32'(bus.sw_clean), 32'h000);
    tick();
    chk("sw3_edge6", 32'(bus.sw_clean), 32'h008);

    // KEY[0] bounces 1,0,1,0 every 2 cycles, then stays pressed
    n_press0 = 0;
    n_rel0   = 0;
    set_in(1'b1, 10'h008, 2'b11);
    tick();
    set_in(1'b1, 10'h008, 2'b10);
    tick();
    set_in(1'b1, 10'h008, 2'b11);
    tick();
    set_in(1'b1, 10'h008, 2'b10);
    repeat (5) tick();
    chk("bounce_no_press", 32'(n_press0), 32'd0);
    tick();
    chk("bounce_press_edge6", 32'(bus.key_press), 32'b01);
    tick();
    chk("bounce_press_single", 32'(n_press0), 32'd1);
    set_in(1'b1, 10'h008, 2'b11);
    repeat (8) tick();
    chk("bounce_release_once", 32'(n_rel0), 32'd1);
    chk("bounce_press_total", 32'(n_press0), 32'd1);

    // Both keys pressed on the same edge
    set_in(1'b1, 10'h008, 2'b00);
    repeat (5) tick();
    chk("both_press_pre", 32'(bus.key_press), 32'b00);
    tick();
    chk("both_press", 32'(bus.key_press), 32'b11);
    tick();
    chk("both_press_end", 32'(bus.key_press), 32'b00);
    chk("both_down", 32'(bus.key_down), 32'b11);
    set_in(1'b1, 10'h008, 2'b11);
    repeat (8) tick();

    // Mode 00 -> 01 -> 11, one change pulse each
    set_in(1'b1, 10'h108, 2'b11);
    repeat (5) tick();
    chk("mode01_pre", 32'(bus.mode), 32'b00);
    tick();
    chk("mode01", 32'(bus.mode), 32'b01);
    chk("mode01_pulse", 32'(bus.mode_change), 32'd1);
    chk("mode01_decode", 32'(decode_mode(bus.mode)), 32'(DESIGN_D2));
    tick();
    chk("mode01_pulse_end", 32'(bus.mode_change), 32'd0);
    set_in(1'b1, 10'h308, 2'b11);
    repeat (5) tick();
    chk("mode11_pre", 32'(bus.mode), 32'b01);
    tick();
    chk("mode11", 32'(bus.mode), 32'b11);
    chk("mode11_pulse", 32'(bus.mode_change), 32'd1);
    chk("mode11_decode", 32'(decode_mode(bus.mode)), 32'(DESIGN_D3));
    tick();
    chk("mode11_pulse_end", 32'(bus.mode_change), 32'd0);

    // Reset while SW[0] is mid-count (cnt = 2): the count must restart from scratch
    set_in(1'b1, 10'h309, 2'b11);
    repeat (3) tick();
    set_in(1'b0, 10'h309, 2'b11);
    set_in(1'b1, 10'h309, 2'b11);
    repeat (5) tick();
    chk("rst_midcount_edge5", 32'(bus.sw_clean), 32'h000);
    tick();
    chk("rst_midcount_edge6", 32'(bus.sw_clean), 32'h309);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
